// File: rtl/spad_window_ctrl.sv
// spad_window_ctrl
// Circular-buffer controller for one PE scratchpad SRAM. Writes arrive as a
// valid/ready stream and land at wr_ptr. Reads are addressed relative to the
// oldest live entry (base). Releases free entries in bulk from the oldest end.
// The SRAM has a registered read port, so read data returns one cycle after
// the request, together with rd_valid.

module spad_window_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 96,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,

    // write stream from the PE input FIFO
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,

    // offset reads from the MAC sequencer
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_offset,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,

    // bulk release from the oldest end
    input  logic                  rel_valid,
    input  logic [CNT_WIDTH-1:0]  rel_num,
    output logic                  rel_err,

    // occupancy
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,

    // SRAM port
    output logic                  sram_chip_en,
    output logic                  sram_wen,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_waddr,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    // One extra bit so base + offset (both below DEPTH) cannot overflow
    // before the conditional subtract.
    localparam int                    SUM_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [SUM_W-1:0]      DEPTH_SUM = SUM_W'(DEPTH);

    // Modular add for a non-power-of-two ring: both operands are below DEPTH
    // (or equal to it for a full release), so one conditional subtract suffices.
    function automatic logic [ADDR_WIDTH-1:0] ring_add(
        input logic [ADDR_WIDTH-1:0] ptr,
        input logic [CNT_WIDTH-1:0]  step
    );
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] wrapped;
        sum     = SUM_W'(ptr) + SUM_W'(step);
        wrapped = (sum >= DEPTH_SUM) ? (sum - DEPTH_SUM) : sum;
        return wrapped[ADDR_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  rd_valid_r;
    logic                  rd_err_r;
    logic                  rel_err_r;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                  in_ready_s;
    logic                  wr_acc_s;
    logic                  rd_in_range_s;
    logic                  rd_acc_s;
    logic                  rd_bad_s;
    logic                  rel_in_range_s;
    logic                  rel_acc_s;
    logic                  rel_bad_s;
    logic [CNT_WIDTH-1:0]  rel_amt_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_next_s;
    logic [ADDR_WIDTH-1:0] base_next_s;
    logic [CNT_WIDTH-1:0]  count_next_s;

    // Accept/reject decisions, all judged against count at the start of the cycle.
    always_comb begin
        in_ready_s     = 1'b0;
        wr_acc_s       = 1'b0;
        rd_in_range_s  = 1'b0;
        rd_acc_s       = 1'b0;
        rd_bad_s       = 1'b0;
        rel_in_range_s = 1'b0;
        rel_acc_s      = 1'b0;
        rel_bad_s      = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s     = (count_r < DEPTH_CNT);
            wr_acc_s       = in_valid & in_ready_s;
            rd_in_range_s  = (CNT_WIDTH'(rd_offset) < count_r);
            rd_acc_s       = rd_req & rd_in_range_s;
            rd_bad_s       = rd_req & ~rd_in_range_s;
            rel_in_range_s = (rel_num <= count_r);
            rel_acc_s      = rel_valid & rel_in_range_s;
            rel_bad_s      = rel_valid & ~rel_in_range_s;
        end
    end

    // Pointer, base and occupancy successors. Reads use the pre-release base,
    // and a same-cycle write only becomes visible through the next count.
    always_comb begin
        rel_amt_s     = {CNT_WIDTH{1'b0}};
        rd_addr_s     = ring_add(base_r, CNT_WIDTH'(rd_offset));
        wr_ptr_next_s = wr_ptr_r;
        base_next_s   = base_r;
        if (wr_acc_s) begin
            wr_ptr_next_s = (wr_ptr_r == LAST_ADDR) ? {ADDR_WIDTH{1'b0}}
                                                    : (wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1});
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (rel_acc_s) begin
            rel_amt_s   = rel_num;
            base_next_s = ring_add(base_r, rel_num);
        end else begin
            rel_amt_s   = {CNT_WIDTH{1'b0}};
            base_next_s = base_r;
        end
        count_next_s = count_r + CNT_WIDTH'(wr_acc_s) - rel_amt_s;
    end

    // Pointer and occupancy registers; full/empty are registered alongside count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            base_r   <= {ADDR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            base_r   <= base_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == DEPTH_CNT);
            empty_r  <= (count_next_s == {CNT_WIDTH{1'b0}});
        end
    end

    // Read-return and error pulses, one cycle after the request; reset drops
    // any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
            rel_err_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            rd_err_r   <= rd_bad_s;
            rel_err_r  <= rel_bad_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. SRAM controls are same-cycle because the SRAM registers them;
    // address/data buses are held at zero when no access is made.
    // ------------------------------------------------------------------
    assign in_ready     = in_ready_s;
    assign rd_valid     = rd_valid_r;
    assign rd_err       = rd_err_r;
    assign rel_err      = rel_err_r;
    assign rd_data      = sram_dout;
    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;

    assign sram_wen     = wr_acc_s;
    assign sram_ren     = rd_acc_s;
    assign sram_chip_en = wr_acc_s | rd_acc_s;
    assign sram_waddr   = wr_acc_s ? wr_ptr_r  : {ADDR_WIDTH{1'b0}};
    assign sram_raddr   = rd_acc_s ? rd_addr_s : {ADDR_WIDTH{1'b0}};
    assign sram_din     = wr_acc_s ? in_data   : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_spad_window_ctrl.sv
// Directed bench for spad_window_ctrl with a behavioural registered-read SRAM.
module tb_spad_window_ctrl;

    localparam int DW = 24;
    localparam int DEPTH = 96;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          rd_req;
    logic [AW-1:0] rd_offset;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          rel_valid;
    logic [CW-1:0] rel_num;
    logic          rel_err;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          sram_chip_en;
    logic          sram_wen;
    logic          sram_ren;
    logic [AW-1:0] sram_waddr;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    logic [DW-1:0] mem [0:DEPTH-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spad_window_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_req(rd_req), .rd_offset(rd_offset), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err),
        .rel_valid(rel_valid), .rel_num(rel_num), .rel_err(rel_err),
        .count(count), .full(full), .empty(empty),
        .sram_chip_en(sram_chip_en), .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_waddr(sram_waddr), .sram_raddr(sram_raddr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Behavioural SRAM with registered read
    always @(posedge clk) begin
        if (sram_wen) mem[sram_waddr] <= sram_din;
        if (sram_ren) sram_dout <= mem[sram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 24'd5;
        rd_req = 1'b0; rd_offset = 7'd0; rel_valid = 1'b0; rel_num = 7'd0;
        // ---------------- T1: reset and fill ----------------
        step(); step();
        settle();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wen", 32'(sram_wen), 32'd0);
        chk("rst_chip_en", 32'(sram_chip_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_err", 32'(rd_err), 32'd0);
        chk("rst_rel_err", 32'(rel_err), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 96; i++) begin
            in_valid = 1'b1; in_data = 24'(i);
            settle();
            chk("fill_ready", 32'(in_ready), 32'd1);
            chk("fill_waddr", 32'(sram_waddr), 32'(i));
            step();
        end
        in_data = 24'd999;
        settle();
        chk("full_count", 32'(count), 32'd96);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_no_wen", 32'(sram_wen), 32'd0);
        step();
        chk("full_count_hold", 32'(count), 32'd96);
        in_valid = 1'b0;

        // ---------------- T2: reads on a full SPad ----------------
        rd_req = 1'b1; rd_offset = 7'd0;
        settle();
        chk("rd0_ren", 32'(sram_ren), 32'd1);
        step();
        rd_offset = 7'd50;
        settle();
        chk("rd0_valid", 32'(rd_valid), 32'd1);
        chk("rd0_data", 32'(rd_data), 32'd0);
        chk("rd50_raddr", 32'(sram_raddr), 32'd50);
        step();
        rd_offset = 7'd95;
        chk("rd50_valid", 32'(rd_valid), 32'd1);
        chk("rd50_data", 32'(rd_data), 32'd50);
        step();
        rd_offset = 7'd96;
        settle();
        chk("rd95_valid", 32'(rd_valid), 32'd1);
        chk("rd95_data", 32'(rd_data), 32'd95);
        chk("rd96_no_ren", 32'(sram_ren), 32'd0);
        chk("rd96_no_chip_en", 32'(sram_chip_en), 32'd0);
        step();
        rd_req = 1'b0;
        chk("rd96_err", 32'(rd_err), 32'd1);
        chk("rd96_valid", 32'(rd_valid), 32'd0);
        step();
        chk("rd_err_pulse", 32'(rd_err), 32'd0);

        // ---------------- T3: release 40, refill with wrap ----------------
        rel_valid = 1'b1; rel_num = 7'd40;
        step();
        rel_valid = 1'b0;
        chk("rel40_count", 32'(count), 32'd56);
        chk("rel40_full", 32'(full), 32'd0);
        chk("rel40_err", 32'(rel_err), 32'd0);
        for (int j = 0; j < 40; j++) begin
            in_valid = 1'b1; in_data = 24'(100 + j);
            settle();
            chk("refill_waddr", 32'(sram_waddr), 32'(j));
            step();
        end
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd96);
        rd_req = 1'b1; rd_offset = 7'd56;
        settle();
        chk("rd56_raddr", 32'(sram_raddr), 32'd0);
        step();
        rd_offset = 7'd55;
        settle();
        chk("rd56_data", 32'(rd_data), 32'd100);
        chk("rd55_raddr", 32'(sram_raddr), 32'd95);
        step();
        rd_req = 1'b0;
        chk("rd55_data", 32'(rd_data), 32'd95);

        // ---------------- T4: over-release, write+release same cycle ----------------
        rel_valid = 1'b1; rel_num = 7'd86;     // base 40 -> 30, count 10
        step();
        rel_num = 7'd11;
        chk("rel86_count", 32'(count), 32'd10);
        step();
        rel_valid = 1'b0;
        chk("rel11_err", 32'(rel_err), 32'd1);
        chk("rel11_count", 32'(count), 32'd10);
        in_valid = 1'b1; in_data = 24'd777;     // lands at address 40
        rel_valid = 1'b1; rel_num = 7'd10;      // base 30 -> 40
        rd_req = 1'b1; rd_offset = 7'd1;        // offset 1 >= count? no: count 10 -> valid read
        settle();
        chk("t4_rd_raddr", 32'(sram_raddr), 32'd31);
        step();
        in_valid = 1'b0; rel_valid = 1'b0; rd_req = 1'b0;
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_empty", 32'(empty), 32'd0);
        chk("t4_rel_err", 32'(rel_err), 32'd0);
        chk("t4_rd_valid", 32'(rd_valid), 32'd1);
        // same-cycle write is not yet readable
        in_valid = 1'b1; in_data = 24'd200;
        rd_req = 1'b1; rd_offset = 7'd1;
        settle();
        chk("t4_sameslot_no_ren", 32'(sram_ren), 32'd0);
        step();
        chk("t4_sameslot_err", 32'(rd_err), 32'd1);
        chk("t4_count2", 32'(count), 32'd2);
        rd_offset = 7'd0; in_valid = 1'b0;
        step();
        rd_req = 1'b0;
        chk("t4_oldest_data", 32'(rd_data), 32'd777);

        // ---------------- T5: full SPad, write+release same cycle ----------------
        for (int k = 0; k < 94; k++) begin
            in_valid = 1'b1; in_data = 24'(300 + k);
            step();
        end
        chk("t5_full", 32'(full), 32'd1);
        in_data = 24'd555; rel_valid = 1'b1; rel_num = 7'd1;
        settle();
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        chk("t5_no_wen", 32'(sram_wen), 32'd0);
        step();
        rel_valid = 1'b0; in_valid = 1'b0;
        settle();
        chk("t5_count", 32'(count), 32'd95);
        chk("t5_ready_back", 32'(in_ready), 32'd1);
        chk("t5_full_clear", 32'(full), 32'd0);

        // ---------------- T6: reset drops a read in flight ----------------
        rd_req = 1'b1; rd_offset = 7'd3;
        step();
        rd_req = 1'b0; rst = 1'b1;
        chk("t6_rd_valid_pre", 32'(rd_valid), 32'd1);
        settle();
        chk("t6_ready_in_rst", 32'(in_ready), 32'd0);
        step();
        chk("t6_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        settle();
        chk("t6_ready_after", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
